// File: rtl/fsm_state_pkg.sv
// ============================================================================
// fsm_state_pkg : shared types and the legal-successor function for the checker
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fsm_state_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ONE   = 4'd1,
    S_TWO   = 4'd2,
    S_THREE = 4'd3,
    S_FOUR  = 4'd4,
    S_FIVE  = 4'd5,
    S_SIX   = 4'd6
  } obs_state_e;

  typedef enum logic [1:0] {
    CHK_SYNC  = 2'd0,
    CHK_TRACK = 2'd1,
    CHK_FAULT = 2'd2
  } chk_state_e;

  // Only the five-state lap has a successor; anything else maps back to IDLE.
  function automatic obs_state_e legal_next(input logic [3:0] s);
    case (s)
      S_IDLE:  legal_next = S_ONE;
      S_ONE:   legal_next = S_TWO;
      S_TWO:   legal_next = S_THREE;
      S_THREE: legal_next = S_FOUR;
      default: legal_next = S_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_state_checker_if.sv
// ============================================================================
// fsm_state_checker_if : sample/control inputs and status outputs of the checker
// Revision             : 1.0
// ============================================================================
`default_nettype none

interface fsm_state_checker_if #(
  parameter int LAP_W = 16
);
  logic             mon_en;
  logic [3:0]       state_in;
  logic             clear;
  logic [LAP_W-1:0] lap_count;
  logic             err_illegal;
  logic             err_sticky;
  logic [3:0]       err_code;
  logic             timeout;
  logic [1:0]       chk_state;

  modport master (
    output mon_en, state_in, clear,
    input  lap_count, err_illegal, err_sticky, err_code, timeout, chk_state
  );

  modport slave (
    input  mon_en, state_in, clear,
    output lap_count, err_illegal, err_sticky, err_code, timeout, chk_state
  );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : enabled up-counter with synchronous clear and saturation at MAX
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o,
  output logic             at_max_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] w_base;

  // Clear applies first so an increment in the same cycle lands on zero.
  always_comb begin
    w_base  = clr_i ? '0 : value_q;
    value_d = (inc_i && (w_base != MAX)) ? w_base + 1'b1 : w_base;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else if (en_i) begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign at_max_o = (value_q == MAX);

endmodule

`default_nettype wire

// File: rtl/fsm_state_checker.sv
// ============================================================================
// fsm_state_checker : passive monitor of the IDLE..FOUR lap, flags illegal moves
//                     and dwell timeouts, counts completed laps
// Revision          : 1.0
// ============================================================================
`default_nettype none

module fsm_state_checker
  import fsm_state_pkg::*;
#(
  parameter int NAME    = 0,
  parameter int TIMEOUT = 16,
  parameter int LAP_W   = 16
) (
  input  logic                aclk,
  input  logic                areset,
  fsm_state_checker_if.slave  bus
);

  localparam int             c_DW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_DW-1:0] c_DWELL_MAX  = c_DW'(TIMEOUT);
  localparam logic [c_DW-1:0] c_DWELL_TRIG = c_DW'(TIMEOUT - 1);

  localparam logic [1:0] ST_SYNC  = CHK_SYNC;
  localparam logic [1:0] ST_TRACK = CHK_TRACK;
  localparam logic [1:0] ST_FAULT = CHK_FAULT;

  logic [1:0] chk_q,    chk_d;
  logic [3:0] prev_q,   prev_d;
  logic       ill_q,    ill_d;
  logic       sticky_q, sticky_d;
  logic [3:0] code_q,   code_d;
  logic       to_q,     to_d;

  logic             w_hold;
  logic             w_dwell_clr;
  logic             w_lap_evt;
  logic [c_DW-1:0]  w_dwell;
  logic             w_dwell_max;
  logic [LAP_W-1:0] w_lap;
  logic             w_lap_max;

  always_comb begin
    chk_d       = chk_q;
    prev_d      = prev_q;
    ill_d       = 1'b0;
    sticky_d    = bus.clear ? 1'b0 : sticky_q;
    code_d      = bus.clear ? 4'd0 : code_q;
    to_d        = bus.clear ? 1'b0 : to_q;
    w_hold      = 1'b0;
    w_dwell_clr = 1'b0;
    w_lap_evt   = 1'b0;
    if (bus.mon_en) begin
      case (chk_q)
        ST_TRACK: begin
          if (bus.state_in == prev_q) begin
            w_hold = 1'b1;
            // Fires only on reaching TIMEOUT, never again while saturated.
            if ((TIMEOUT != 0) && (w_dwell == c_DWELL_TRIG) && !bus.clear) begin
              to_d = 1'b1;
            end
          end else if (bus.state_in == legal_next(prev_q)) begin
            prev_d      = bus.state_in;
            w_dwell_clr = 1'b1;
            w_lap_evt   = (prev_q == S_FOUR);
          end else begin
            ill_d    = 1'b1;
            sticky_d = 1'b1;
            if (!sticky_q || bus.clear) begin
              code_d = bus.state_in;
            end
            chk_d = ST_FAULT;
          end
        end
        ST_SYNC, ST_FAULT: begin
          if (bus.state_in == S_IDLE) begin
            chk_d       = ST_TRACK;
            prev_d      = S_IDLE;
            w_dwell_clr = 1'b1;
          end
        end
        default: chk_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      chk_q    <= ST_SYNC;
      prev_q   <= S_IDLE;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
      code_q   <= 4'd0;
      to_q     <= 1'b0;
    end else begin
      chk_q    <= chk_d;
      prev_q   <= prev_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
      code_q   <= code_d;
      to_q     <= to_d;
    end
  end

  sat_counter #(
    .WIDTH (c_DW),
    .MAX   (c_DWELL_MAX)
  ) u_dwell (
    .clk_i    (aclk),
    .rst_i    (areset),
    .en_i     (bus.mon_en),
    .clr_i    (w_dwell_clr),
    .inc_i    (w_hold && !w_dwell_max),
    .value_o  (w_dwell),
    .at_max_o (w_dwell_max)
  );

  // Enabled by clear too, so laps can be zeroed while sampling is paused.
  sat_counter #(
    .WIDTH (LAP_W)
  ) u_laps (
    .clk_i    (aclk),
    .rst_i    (areset),
    .en_i     (bus.mon_en || bus.clear),
    .clr_i    (bus.clear),
    .inc_i    (w_lap_evt && (bus.clear || !w_lap_max)),
    .value_o  (w_lap),
    .at_max_o (w_lap_max)
  );

  assign bus.lap_count   = w_lap;
  assign bus.err_illegal = ill_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.err_code    = code_q;
  assign bus.timeout     = to_q;
  assign bus.chk_state   = chk_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_state_checker.sv
// ============================================================================
// tb_fsm_state_checker : directed bench for fsm_state_checker
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_state_checker;

  logic       aclk = 1'b0;
  logic       areset;
  logic       mon_en;
  logic [3:0] state_in;
  logic       clear;
  int         checks   = 0;
  int         failures = 0;

  always #5 aclk = ~aclk;

  fsm_state_checker_if #(.LAP_W(16)) bus_a ();
  fsm_state_checker_if #(.LAP_W(2))  bus_b ();

  assign bus_a.mon_en   = mon_en;
  assign bus_a.state_in = state_in;
  assign bus_a.clear    = clear;
  assign bus_b.mon_en   = mon_en;
  assign bus_b.state_in = state_in;
  assign bus_b.clear    = clear;

  fsm_state_checker #(.NAME(0), .TIMEOUT(4), .LAP_W(16)) dut_a (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus_a.slave)
  );

  fsm_state_checker #(.NAME(1), .TIMEOUT(16), .LAP_W(2)) dut_b (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic en, input logic clr);
    state_in = s;
    mon_en   = en;
    clear    = clr;
    @(posedge aclk);
    #1;
  endtask

  task automatic lap(input logic en_gap);
    for (int k = 1; k <= 5; k++) begin
      step(4'(k % 5), 1'b1, 1'b0);
      if (en_gap) begin
        step(4'd6, 1'b0, 1'b0);
        chk("gap_no_err", bus_a.err_illegal, 0);
      end
    end
  endtask

  initial begin
    areset   = 1'b1;
    mon_en   = 1'b0;
    state_in = 4'd0;
    clear    = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("rst_lap",    bus_a.lap_count, 0);
    chk("rst_ill",    bus_a.err_illegal, 0);
    chk("rst_sticky", bus_a.err_sticky, 0);
    chk("rst_code",   bus_a.err_code, 0);
    chk("rst_to",     bus_a.timeout, 0);
    chk("rst_chk",    bus_a.chk_state, 0);
    areset = 1'b0;

    // One full lap
    step(4'd0, 1'b1, 1'b0);
    chk("sync_to_track", bus_a.chk_state, 1);
    step(4'd1, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    step(4'd4, 1'b1, 1'b0);
    chk("lap_before_idle", bus_a.lap_count, 0);
    step(4'd0, 1'b1, 1'b0);
    chk("lap1_count",  bus_a.lap_count, 1);
    chk("lap1_chk",    bus_a.chk_state, 1);
    chk("lap1_sticky", bus_a.err_sticky, 0);
    chk("lap1_to",     bus_a.timeout, 0);

    // Skip ONE->THREE, then garbage in FAULT, then resync
    step(4'd1, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    chk("ill_pulse",  bus_a.err_illegal, 1);
    chk("ill_code",   bus_a.err_code, 3);
    chk("ill_sticky", bus_a.err_sticky, 1);
    chk("ill_chk",    bus_a.chk_state, 2);
    step(4'd5, 1'b1, 1'b0);
    chk("fault_no_pulse", bus_a.err_illegal, 0);
    chk("fault_code",     bus_a.err_code, 3);
    chk("fault_chk",      bus_a.chk_state, 2);
    step(4'd0, 1'b1, 1'b0);
    chk("resync_chk",    bus_a.chk_state, 1);
    chk("resync_sticky", bus_a.err_sticky, 1);

    // Dwell: four holds of TWO trip TIMEOUT=4
    step(4'd1, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    chk("hold3_no_to", bus_a.timeout, 0);
    step(4'd2, 1'b1, 1'b0);
    chk("hold4_to", bus_a.timeout, 1);
    chk("hold4_no_err", bus_a.err_illegal, 0);

    // Clear while saturated: no re-trigger, then only three holds of THREE
    step(4'd2, 1'b1, 1'b1);
    chk("clr_to",     bus_a.timeout, 0);
    chk("clr_sticky", bus_a.err_sticky, 0);
    chk("clr_code",   bus_a.err_code, 0);
    chk("clr_lap",    bus_a.lap_count, 0);
    chk("clr_chk",    bus_a.chk_state, 1);
    step(4'd2, 1'b1, 1'b0);
    chk("sat_no_retrig", bus_a.timeout, 0);
    step(4'd3, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    chk("hold3_only", bus_a.timeout, 0);
    step(4'd4, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    chk("lap_after_clr", bus_a.lap_count, 1);

    // Three laps with mon_en toggling; garbage while disabled
    step(4'd0, 1'b1, 1'b1);
    chk("clr_hold_lap", bus_a.lap_count, 0);
    lap(1'b1);
    lap(1'b1);
    lap(1'b1);
    chk("gated_laps",   bus_a.lap_count, 3);
    chk("gated_sticky", bus_a.err_sticky, 0);
    chk("gated_chk",    bus_a.chk_state, 1);

    // Clear coincident with an illegal move while sticky already set
    step(4'd1, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    chk("pre_code", bus_a.err_code, 3);
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    step(4'd6, 1'b1, 1'b1);
    chk("clrill_sticky", bus_a.err_sticky, 1);
    chk("clrill_code",   bus_a.err_code, 6);
    chk("clrill_lap",    bus_a.lap_count, 0);
    chk("clrill_pulse",  bus_a.err_illegal, 1);
    step(4'd6, 1'b0, 1'b0);
    chk("en0_pulse_drop", bus_a.err_illegal, 0);
    chk("en0_chk_hold",   bus_a.chk_state, 2);

    // Asynchronous reset at THREE, away from any clock edge
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    #3;
    areset = 1'b1;
    #1;
    chk("arst_lap",    bus_a.lap_count, 0);
    chk("arst_sticky", bus_a.err_sticky, 0);
    chk("arst_code",   bus_a.err_code, 0);
    chk("arst_chk",    bus_a.chk_state, 0);
    chk("arst_to",     bus_a.timeout, 0);
    #2;
    areset = 1'b0;
    step(4'd2, 1'b1, 1'b0);
    step(4'd3, 1'b1, 1'b0);
    chk("post_rst_sync",   bus_a.chk_state, 0);
    chk("post_rst_noerr",  bus_a.err_sticky, 0);
    step(4'd0, 1'b1, 1'b0);
    chk("post_rst_track",  bus_a.chk_state, 1);

    // Five laps saturate the 2-bit counter
    step(4'd0, 1'b1, 1'b1);
    lap(1'b0);
    lap(1'b0);
    lap(1'b0);
    chk("sat3_b", bus_b.lap_count, 3);
    lap(1'b0);
    lap(1'b0);
    chk("sat5_b", bus_b.lap_count, 3);
    chk("sat5_a", bus_a.lap_count, 5);
    chk("sat5_b_err", bus_b.err_sticky, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
